// File: rtl/pipeline_pkg.sv
// Shared pipeline types: fetch FSM states, the canonical NOP and the IF/ID payload.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/ifetch_hold_buf.sv
// One-entry {instr, pc} parking slot for a response that lands while decode is stalled.
module ifetch_hold_buf #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [31:0]     push_instr,
  input  logic [XLEN-1:0] push_pc,
  output logic            valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc
);

  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    // NOTE: every signal gets its default first so no path leaves it unassigned (no latch).
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (push) begin
      valid_d = 1'b1;
      instr_d = push_instr;
      pc_d    = push_pc;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignment so all flops update from pre-edge values.
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  // NOTE: payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    pc_q    <= pc_d;
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/ifetch_stage.sv
// IF stage: PC register, single-outstanding valid/ready fetch, redirect-drop and IF/ID register.
module ifetch_stage #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter logic [31:0]      NOP_INSTR    = pipeline_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallD,
  input  logic            FlushD,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            FetchBusyF
);

  import pipeline_pkg::*;

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(3);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;
  logic            ifid_valid_q, ifid_valid_d;

  logic            req_fire;
  logic            deliver;
  logic            hold_valid, hold_push, hold_pop, hold_clear;
  logic [31:0]     hold_instr;
  logic [XLEN-1:0] hold_pc;
  logic [XLEN-1:0] target_aligned;

  assign target_aligned = PCTargetE & ~ALIGN_MASK;

  // Fetch FSM and PC: a response in WAIT may retire while the next request issues.
  always_comb begin
    state_d  = state_q;
    pcf_d    = pcf_q;
    pc_out_d = pc_out_q;
    deliver  = 1'b0;

    imem_req_valid = reset && !PCSrcE && !hold_valid &&
                     ((state_q == RUN) ||
                      (state_q == WAIT && imem_resp_valid && !StallD));
    req_fire = imem_req_valid && imem_req_ready;

    case (state_q)
      RUN: begin
        if (req_fire) state_d = WAIT;
      end
      WAIT: begin
        if (PCSrcE) begin
          state_d = imem_resp_valid ? RUN : DROP;
        end else if (imem_resp_valid) begin
          deliver = 1'b1;
          state_d = req_fire ? WAIT : RUN;
        end
      end
      DROP: begin
        if (imem_resp_valid) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (PCSrcE) begin
      pcf_d = target_aligned;
    end else if (req_fire) begin
      pcf_d    = pcf_q + PC_STEP;
      pc_out_d = pcf_q;
    end
  end

  // IF/ID update, kill > stall > hold drain > fresh response > bubble.
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    hold_push    = 1'b0;
    hold_pop     = 1'b0;
    hold_clear   = 1'b0;

    if (PCSrcE || FlushD) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      hold_clear   = 1'b1;
    end else if (StallD) begin
      hold_push = deliver;
    end else if (hold_valid) begin
      ifid_instr_d = hold_instr;
      ifid_pc_d    = hold_pc;
      ifid_pc4_d   = hold_pc + PC_STEP;
      ifid_valid_d = 1'b1;
      hold_pop     = 1'b1;
    end else if (deliver) begin
      ifid_instr_d = imem_resp_data;
      ifid_pc_d    = pc_out_q;
      ifid_pc4_d   = pc_out_q + PC_STEP;
      ifid_valid_d = 1'b1;
    end else begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= RUN;
      pcf_q        <= RESET_VECTOR;
      pc_out_q     <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      pc_out_q     <= pc_out_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  ifetch_hold_buf #(.XLEN(XLEN)) u_hold_buf (
    .clk        (clk),
    .rst_n      (reset),
    .push       (hold_push),
    .pop        (hold_pop),
    .clear      (hold_clear),
    .push_instr (imem_resp_data),
    .push_pc    (pc_out_q),
    .valid      (hold_valid),
    .instr      (hold_instr),
    .pc         (hold_pc)
  );

  assign imem_req_addr = pcf_q;
  assign InstrD        = ifid_instr_q;
  assign PCD           = ifid_pc_q;
  assign PCPlus4D      = ifid_pc4_q;
  assign ValidD        = ifid_valid_q;
  assign FetchBusyF    = (state_q != RUN) || hold_valid;

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: bench-side memory responder plus an in-order IF/ID scoreboard.
module tb_ifetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RV  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallD;
  logic        FlushD;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        FetchBusyF;

  always #5 clk = ~clk;

  ifetch_stage #(.XLEN(32), .RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
    .clk             (clk),
    .reset           (reset),
    .PCSrcE          (PCSrcE),
    .PCTargetE       (PCTargetE),
    .StallD          (StallD),
    .FlushD          (FlushD),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .InstrD          (InstrD),
    .PCD             (PCD),
    .PCPlus4D        (PCPlus4D),
    .ValidD          (ValidD),
    .FetchBusyF      (FetchBusyF)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          lat = 1;
  int          cyc = 0;
  logic [31:0] exp_pc;
  bit          pend;
  int          resp_wait;
  logic [31:0] resp_pc;
  bit          resp_keep;
  bit          rv_seen;
  logic [31:0] last_req_addr;
  int          first_req_cyc = -1;
  int          first_valid_cyc = -1;
  logic        last_valid;
  logic [31:0] last_instr, last_pc, last_pc4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0010_0093;
      32'h8:   return 32'h0020_0113;
      default: return 32'hA000_0000 | a;
    endcase
  endfunction

  // One clock cycle: drive the memory response, observe the request, clock, then score IF/ID.
  task automatic cycle();
    bit   kill;
    exp_t e;
    kill = PCSrcE || FlushD || !reset;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    if (pend) begin
      resp_wait--;
      if (resp_wait == 0) begin
        pend            = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = resp_keep ? mem_word(resp_pc) : 32'hDEAD_BEEF;
        if (resp_keep && !kill) begin
          e.instr = imem_resp_data;
          e.pc    = resp_pc;
          sb.push_back(e);
        end
      end else if (PCSrcE) begin
        resp_keep = 1'b0;
      end
    end
    #1;
    rv_seen = imem_req_valid;
    if (!reset) check("req_valid_in_reset", 32'(rv_seen), 32'd0);
    if (imem_req_valid && imem_req_ready) begin
      check("one_outstanding", 32'(pend), 32'd0);
      check("req_addr", imem_req_addr, exp_pc);
      last_req_addr = imem_req_addr;
      if (first_req_cyc < 0) first_req_cyc = cyc;
      pend      = 1'b1;
      resp_wait = lat;
      resp_pc   = exp_pc;
      resp_keep = 1'b1;
      exp_pc    = exp_pc + 32'd4;
    end
    if (PCSrcE) exp_pc = PCTargetE & ~32'h3;

    @(posedge clk);
    #1;
    cyc++;
    if (!reset) begin
      exp_pc = RV;
      pend   = 1'b0;
      sb.delete();
      last_valid = 1'b0; last_instr = NOP; last_pc = 32'h0; last_pc4 = 32'h0;
      check("reset_validd",  32'(ValidD), 32'd0);
      check("reset_instrd",  InstrD, NOP);
      check("reset_pcd",     PCD, 32'h0);
      check("reset_pcplus4", PCPlus4D, 32'h0);
      check("reset_busy",    32'(FetchBusyF), 32'd0);
    end else if (kill) begin
      sb.delete();
      last_valid = 1'b0; last_instr = NOP;
      check("kill_validd", 32'(ValidD), 32'd0);
      check("kill_instrd", InstrD, NOP);
    end else if (StallD) begin
      check("stall_validd",  32'(ValidD), 32'(last_valid));
      check("stall_instrd",  InstrD, last_instr);
      check("stall_pcd",     PCD, last_pc);
      check("stall_pcplus4", PCPlus4D, last_pc4);
    end else if (ValidD === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(ValidD), 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_instr",    InstrD, e.instr);
        check("sb_pcd",      PCD, e.pc);
        check("sb_pcplus4",  PCPlus4D, e.pc + 32'd4);
        last_valid = 1'b1; last_instr = e.instr; last_pc = e.pc; last_pc4 = e.pc + 32'd4;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
    end else begin
      check("bubble_instrd", InstrD, NOP);
      last_valid = 1'b0; last_instr = NOP;
    end
  endtask

  initial begin
    reset = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0; StallD = 1'b0; FlushD = 1'b0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    exp_pc = RV; pend = 1'b0; resp_wait = 0; resp_pc = 32'h0; resp_keep = 1'b0;
    last_req_addr = 32'h0;
    last_valid = 1'b0; last_instr = NOP; last_pc = 32'h0; last_pc4 = 32'h0;
    #2;

    cycle();
    cycle();
    reset = 1'b1;

    // Streaming at one instruction per cycle: 0x0, 0x4.
    cycle();
    cycle();
    cycle();
    check("first_latency", 32'(first_valid_cyc - first_req_cyc), 32'd2);
    check("stream_pcd_4", PCD, 32'h4);

    // Response for 0x8 lands while decode is stalled for three cycles.
    StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_no_req", 32'(rv_seen), 32'd0);
      check("stall_hold_busy", 32'(FetchBusyF), 32'd1);
    end
    StallD = 1'b0;
    cycle();
    check("hold_drain_no_req", 32'(rv_seen), 32'd0);
    check("after_stall_pcd", PCD, 32'h8);
    check("after_stall_valid", 32'(ValidD), 32'd1);

    // Three-cycle memory latency.
    lat = 3;
    cycle();
    check("slow_busy", 32'(FetchBusyF), 32'd1);
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("slow_no_rereq", 32'(rv_seen), 32'd0);
      check("slow_busy", 32'(FetchBusyF), 32'd1);
      check("slow_bubble", 32'(ValidD), 32'd0);
    end
    cycle();
    check("slow_pcd", PCD, 32'hC);

    // Redirect to 0x40 while the fetch of 0x10 is in flight.
    PCSrcE = 1'b1; PCTargetE = 32'h40;
    cycle();
    check("redirect_no_req", 32'(rv_seen), 32'd0);
    PCSrcE = 1'b0;
    cycle();
    check("drop_busy", 32'(FetchBusyF), 32'd1);
    cycle();
    check("drop_discarded", 32'(ValidD), 32'd0);
    lat = 1;
    cycle();
    check("redirect_req_seen", 32'(rv_seen), 32'd1);
    check("redirect_addr", last_req_addr, 32'h40);

    // Redirect to unaligned 0x103 on the cycle the response arrives.
    PCSrcE = 1'b1; PCTargetE = 32'h103;
    cycle();
    check("redir_resp_no_req", 32'(rv_seen), 32'd0);
    check("redir_resp_valid", 32'(ValidD), 32'd0);
    PCSrcE = 1'b0;
    cycle();
    check("aligned_target_addr", last_req_addr, 32'h100);
    cycle();
    check("target_stream_pcd", PCD, 32'h100);

    // One-cycle reset mid-stream.
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    check("post_reset_addr", last_req_addr, RV);
    cycle();

    // Flush drops the arriving response but not the next fetch.
    FlushD = 1'b1;
    cycle();
    FlushD = 1'b0;
    cycle();
    check("post_flush_pcd", PCD, 32'h8);

    // Back-pressure: requests wait at the memory; drain the scoreboard.
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("backpressure_req_valid", 32'(imem_req_valid), 32'd1);
    check("backpressure_addr", imem_req_addr, 32'h10);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
